// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the MEM/WB writeback slice.
//   - Load-type encodings carried by mem_load_type.
//   - Default datapath and register-address widths.
//   - The hard-wired zero register index.
package mem_wb_writeback_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wb_writeback_load_extract.sv
// Sub-word load extraction (the load_extract block).
// Purely combinational so it can be reused by a future load-forwarding path.
// Ports:
//   load_type  in   3       LT_* encoding; unknown codes behave as lw
//   off        in   2       byte offset of the effective address
//   word       in   DATA_W  aligned word read from data memory
//   result     out  DATA_W  extended load value
module mem_wb_writeback_load_extract
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] lane_shift;
    logic [7:0]        lane;
    logic [15:0]       half;

    // Byte lane k sits at bits [8k+7:8k]; shift it down to bit 0.
    assign lane_shift = word >> {off, 3'b000};
    assign lane       = lane_shift[7:0];
    // off[0] is ignored: misaligned halfwords are not trapped.
    assign half       = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (load_type)
            LT_LH:   result = {{(DATA_W-16){half[15]}}, half};
            LT_LHU:  result = {{(DATA_W-16){1'b0}}, half};
            LT_LB:   result = {{(DATA_W-8){lane[7]}}, lane};
            LT_LBU:  result = {{(DATA_W-8){1'b0}}, lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register plus writeback select. Drives the register file
// write port (C = wb_dest, Cdata = wb_data, sel = wb_write_en).
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   stall, flush         hold contents / insert a bubble (flush wins)
//   mem_*                MEM-stage control and data to be captured
//   wb_write_en          register file write enable, never set for $0
//   wb_dest              register file write address
//   wb_data              register file write data (driven even when not writing)
//   retired              count of captured valid instructions, wraps
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_link,
    input  logic [2:0]        mem_load_type,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_pc_plus8,
    output logic              wb_write_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired
);

    logic              valid_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic              link_q;
    logic [2:0]        load_type_q;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] pc_plus8_q;
    logic [31:0]       retired_q;

    logic [DATA_W-1:0] load_value;

    // Priority: rst > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= LT_LW;
            dest_q       <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus8_q   <= '0;
            retired_q    <= '0;
        end else if (flush) begin
            // Bubble; the retire count is left alone.
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= LT_LW;
            dest_q       <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus8_q   <= '0;
        end else if (!stall) begin
            valid_q      <= mem_valid;
            reg_write_q  <= mem_reg_write;
            mem_to_reg_q <= mem_mem_to_reg;
            link_q       <= mem_link;
            load_type_q  <= mem_load_type;
            dest_q       <= mem_dest;
            alu_result_q <= mem_alu_result;
            read_data_q  <= mem_read_data;
            pc_plus8_q   <= mem_pc_plus8;
            if (mem_valid) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    mem_wb_writeback_load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .load_type (load_type_q),
        .off       (alu_result_q[1:0]),
        .word      (read_data_q),
        .result    (load_value)
    );

    always_comb begin
        wb_write_en = valid_q & reg_write_q & (dest_q != ADDR_W'(REG_ZERO));
        wb_dest     = dest_q;
        if (link_q) begin
            wb_data = pc_plus8_q;
        end else if (mem_to_reg_q) begin
            wb_data = load_value;
        end else begin
            wb_data = alu_result_q;
        end
    end

    assign retired = retired_q;

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback-select logic.
- Drives the register file write port: write address, write data and write enable.
- It is the producer for the register file's write port, which consumes those signals as C, Cdata and sel.
- Also extracts sub-word load data, suppresses writes to $0, supports stall/flush, and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold WB register contents.
- flush  in  1  replace WB contents with a bubble.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes a register.
- mem_mem_to_reg  in  1  result comes from load data.
- mem_link  in  1  result is the link address (jal/jalr).
- mem_load_type  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu; other codes are treated as lw.
- mem_dest  in  ADDR_W  destination register.
- mem_alu_result  in  DATA_W  ALU result / effective address.
- mem_read_data  in  DATA_W  word read from data memory.
- mem_pc_plus8  in  DATA_W  link value.
- wb_write_en  out  1  register file write enable (sel).
- wb_dest  out  ADDR_W  register file write address (C).
- wb_data  out  DATA_W  register file write data (Cdata).
- retired  out  32  count of retired valid instructions.

Behaviour:
- State: valid, reg_write, mem_to_reg, link, load_type, dest, alu_result, read_data, pc_plus8, retire counter.
- Reset:
  - All state is cleared to 0 on the first rising edge with rst=1; rst overrides flush and stall.
  - After reset: wb_write_en=0, wb_dest=0, wb_data=0, retired=0.
- Update priority at each edge: rst > flush > stall > capture.
  - flush: valid and all control/data fields are cleared to 0 (bubble).
  - stall: all state is held, including the counter.
  - capture: every mem_* input is latched into its register.
- Latency: a value presented at edge N is visible on the outputs after edge N. The register file commits it at edge N+1.
- Output logic is combinational from the WB registers only; there is no input-to-output path.
- wb_write_en = valid & reg_write & (dest != 0). Writes to $0 are never asserted.
- wb_dest = dest.
- wb_data selection, in priority order:
  - link → pc_plus8;
  - else mem_to_reg → extracted load value;
  - else alu_result.
  - wb_data is driven even when wb_write_en=0.
- Load extraction uses byte offset off = alu_result[1:0]. Byte lane k = read_data[8k+7:8k]; half h = read_data[16h+15:16h] with h = off[1]. off[0] is ignored for halves (misaligned halfword is not trapped).
  - lw: the full read_data word.
  - lh: sign-extend half h.
  - lhu: zero-extend half h.
  - lb: sign-extend lane off.
  - lbu: zero-extend lane off.
- Retire counter: increments by 1 at a capture edge with mem_valid=1. It does not increment on flush, stall or reset edges, and wraps from 0xFFFFFFFF to 0.
- Stall and flush asserted together: flush wins and the bubble is inserted.
- Reset mid-stall: the state is cleared regardless; any pending write is lost.

Decomposition:
- Shared package holds:
  - load-type constants LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4;
  - DATA_W and ADDR_W defaults;
  - REG_ZERO=5'd0.
- One natural combinational sub-module, load_extract, with ports (load_type, off, word, result). It is reusable by any future load-forwarding path.

Test Plan:
- Reset: hold rst=1 for two edges with random inputs → all outputs 0 and retired=0.
- ALU writeback: mem_valid=1, reg_write=1, dest=10, alu_result=0x0000000A → after one edge, wb_write_en=1, wb_dest=10, wb_data=0x0A, retired=1.
- $0 guard: the same capture with dest=0 → wb_write_en=0 and retired still increments.
- Loads with read_data=0x8081F2F3:
  - lb, off=1 → 0xFFFFFFF2.
  - lbu, off=1 → 0x000000F2.
  - lh, off=2 → 0xFFFF8081.
  - lhu, off=0 → 0x0000F2F3.
  - lw → 0x8081F2F3.
- Link: link=1, mem_to_reg=1, pc_plus8=0x00400010, dest=31 → wb_data=0x00400010 (link overrides mem_to_reg).
- Stall/flush:
  - A valid write is captured, then stall=1 for 3 edges with new inputs → outputs unchanged and retired unchanged.
  - Then stall=1 and flush=1 together → wb_write_en=0, wb_data=0, retired unchanged.
